// File: rtl/vga_param_controller.sv
// Parametrised VGA timing generator with RGB332 expansion and colour-bar test pattern.
// Latency: pixel request (o_REQ/o_X/o_Y) leads colour/DE/sync/FRAME outputs by 1 cycle.
// Backpressure: none; free-running at the pixel clock, the source must supply i_RGB on o_REQ.
module vga_param_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int OUT_BITS = 4,
    parameter int CW       = 10
) (
    input  logic                i_CLK,
    input  logic                i_RESET,
    input  logic [7:0]          i_RGB,
    input  logic                i_PATTERN_EN,
    output logic                o_REQ,
    output logic [CW-1:0]       o_X,
    output logic [CW-1:0]       o_Y,
    output logic                o_HSYNC,
    output logic                o_VSYNC,
    output logic                o_DE,
    output logic                o_FRAME,
    output logic [OUT_BITS-1:0] o_RED,
    output logic [OUT_BITS-1:0] o_GREEN,
    output logic [OUT_BITS-1:0] o_BLUE
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SS     = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SE     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SS     = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SE     = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);

    // run_q holds the counters at (0,0) for one cycle after reset so that the
    // first request after release is pixel (0,0) and never a reset artefact.
    logic                run_q;
    logic [CW-1:0]       h_cnt_q, h_cnt_d;
    logic [CW-1:0]       v_cnt_q, v_cnt_d;
    logic                pat_q, pat_d;
    logic [CW-1:0]       bar_pix_q, bar_pix_d;
    logic [2:0]          bar_idx_q, bar_idx_d;

    logic                de_q, de_d;
    logic                hs_q, hs_d;
    logic                vs_q, vs_d;
    logic                frame_q, frame_d;
    logic [OUT_BITS-1:0] red_q, red_d;
    logic [OUT_BITS-1:0] grn_q, grn_d;
    logic [OUT_BITS-1:0] blu_q, blu_d;

    logic                req;
    logic                frame_start;
    logic                pat_cur;
    logic                hs_act;
    logic                vs_act;
    logic [CW-1:0]       bar_pix_cur;
    logic [2:0]          bar_idx_cur;
    logic [OUT_BITS-1:0] r_exp, g_exp, b_exp;

    // MSB-first replication of each RGB332 field up to the output depth.
    for (genvar i = 0; i < OUT_BITS; i++) begin : g_expand
        assign r_exp[OUT_BITS-1-i] = i_RGB[7 - (i % 3)];
        assign g_exp[OUT_BITS-1-i] = i_RGB[4 - (i % 3)];
        assign b_exp[OUT_BITS-1-i] = i_RGB[1 - (i % 2)];
    end

    assign req         = run_q && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign frame_start = run_q && (h_cnt_q == '0) && (v_cnt_q == '0);
    // Mode only changes at the first pixel of a frame, so a frame never tears.
    assign pat_cur     = frame_start ? i_PATTERN_EN : pat_q;
    assign hs_act      = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
    assign vs_act      = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
    assign bar_pix_cur = (h_cnt_q == '0) ? '0 : bar_pix_q;
    assign bar_idx_cur = (h_cnt_q == '0) ? 3'd0 : bar_idx_q;

    // Next-state for counters, latched mode and bar tracker.
    always_comb begin
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        pat_d     = pat_q;
        bar_pix_d = bar_pix_cur;
        bar_idx_d = bar_idx_cur;
        if (run_q) begin
            pat_d = pat_cur;
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
            end else begin
                h_cnt_d = h_cnt_q + CW'(1);
            end
            if (bar_pix_cur == BAR_LAST) begin
                bar_pix_d = '0;
                bar_idx_d = bar_idx_cur + 3'd1;
            end else begin
                bar_pix_d = bar_pix_cur + CW'(1);
            end
        end
    end

    // Output stage next-state: colour source select, blanking and sync levels.
    always_comb begin
        de_d    = req;
        hs_d    = hs_act ? HS_POL : ~HS_POL;
        vs_d    = vs_act ? VS_POL : ~VS_POL;
        frame_d = frame_start;
        red_d   = '0;
        grn_d   = '0;
        blu_d   = '0;
        if (req) begin
            if (pat_cur) begin
                // Bars white..black: R/G/B are the inverted idx bits 1/2/0.
                red_d = {OUT_BITS{~bar_idx_cur[1]}};
                grn_d = {OUT_BITS{~bar_idx_cur[2]}};
                blu_d = {OUT_BITS{~bar_idx_cur[0]}};
            end else begin
                red_d = r_exp;
                grn_d = g_exp;
                blu_d = b_exp;
            end
        end
    end

    // Timing state registers.
    always_ff @(posedge i_CLK) begin
        if (!i_RESET) begin
            run_q     <= 1'b0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            pat_q     <= 1'b0;
            bar_pix_q <= '0;
            bar_idx_q <= 3'd0;
        end else begin
            run_q     <= 1'b1;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            pat_q     <= pat_d;
            bar_pix_q <= bar_pix_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    // Output registers, one cycle behind the counters.
    always_ff @(posedge i_CLK) begin
        if (!i_RESET) begin
            de_q    <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            frame_q <= 1'b0;
            red_q   <= '0;
            grn_q   <= '0;
            blu_q   <= '0;
        end else begin
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            frame_q <= frame_d;
            red_q   <= red_d;
            grn_q   <= grn_d;
            blu_q   <= blu_d;
        end
    end

    assign o_REQ   = req;
    assign o_X     = h_cnt_q;
    assign o_Y     = v_cnt_q;
    assign o_HSYNC = hs_q;
    assign o_VSYNC = vs_q;
    assign o_DE    = de_q;
    assign o_FRAME = frame_q;
    assign o_RED   = red_q;
    assign o_GREEN = grn_q;
    assign o_BLUE  = blu_q;

endmodule

// File: tb/tb_vga_param_controller.sv
// Bench for vga_param_controller: small-timing instances at 4 and 8 bit depth plus a default instance.
// Expected outputs are queued per cycle by the stimulus and popped by a monitor one edge later.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_vga_param_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rst_def_n;
    logic       pat_en;
    logic [7:0] rgb;

    logic       req4, hs4, vs4, de4, fr4;
    logic [9:0] x4, y4;
    logic [3:0] r4, g4, b4;
    logic       req8, hs8, vs8, de8, fr8;
    logic [9:0] x8, y8;
    logic [7:0] r8, g8, b8;
    logic       reqd, hsd, vsd, ded, frd;
    logic [9:0] xd, yd;
    logic [3:0] rd, gd, bd;

    vga_param_controller #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .OUT_BITS(4), .CW(10)
    ) u_s4 (
        .i_CLK(clk), .i_RESET(rst_n), .i_RGB(rgb), .i_PATTERN_EN(pat_en),
        .o_REQ(req4), .o_X(x4), .o_Y(y4), .o_HSYNC(hs4), .o_VSYNC(vs4),
        .o_DE(de4), .o_FRAME(fr4), .o_RED(r4), .o_GREEN(g4), .o_BLUE(b4)
    );

    vga_param_controller #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .OUT_BITS(8), .CW(10)
    ) u_s8 (
        .i_CLK(clk), .i_RESET(rst_n), .i_RGB(rgb), .i_PATTERN_EN(pat_en),
        .o_REQ(req8), .o_X(x8), .o_Y(y8), .o_HSYNC(hs8), .o_VSYNC(vs8),
        .o_DE(de8), .o_FRAME(fr8), .o_RED(r8), .o_GREEN(g8), .o_BLUE(b8)
    );

    vga_param_controller u_def (
        .i_CLK(clk), .i_RESET(rst_def_n), .i_RGB(8'h5A), .i_PATTERN_EN(1'b0),
        .o_REQ(reqd), .o_X(xd), .o_Y(yd), .o_HSYNC(hsd), .o_VSYNC(vsd),
        .o_DE(ded), .o_FRAME(frd), .o_RED(rd), .o_GREEN(gd), .o_BLUE(bd)
    );

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fr;
        logic [11:0] c4;
        logic [23:0] c8;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   def_done = 1'b0;

    // Reference model state for the small-timing instances.
    int mh = 0, mv = 0, mframe = 0;
    bit mrun = 1'b0, mpat = 1'b0, pulse_done = 1'b0;

    // Hand-computed colour tables.
    logic [11:0] bars4 [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    logic [23:0] bars8 [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    logic [7:0]  tbl_rgb [3] = '{8'hFF, 8'h00, 8'hA2};
    logic [11:0] tbl4    [3] = '{12'hFFF, 12'h000, 12'hB0A};
    logic [23:0] tbl8    [3] = '{24'hFFFFFF, 24'h000000, 24'hB600AA};

    function automatic logic [11:0] xp4(input logic [7:0] p);
        return {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
    endfunction

    function automatic logic [23:0] xp8(input logic [7:0] p);
        return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], p[1:0], p[1:0], p[1:0], p[1:0]};
    endfunction

    // One cycle of stimulus: check request side, queue expected outputs, advance model.
    task automatic drive(input bit r, input bit pe, input logic [7:0] px,
                         input bit use_tbl, input logic [11:0] t4, input logic [23:0] t8);
        bit   exp_req, fs, effpat;
        exp_t e;
        rst_n  = r;
        pat_en = pe;
        rgb    = px;
        exp_req = mrun && (mh < 8) && (mv < 4);
        checks++;
        if ({req4, x4, y4} !== {exp_req, 10'(mh), 10'(mv)} ||
            {req8, x8, y8} !== {exp_req, 10'(mh), 10'(mv)}) begin
            errors++;
            $display("FAIL req_xy: got req=%0b x=%0d y=%0d (8b: %0b %0d %0d) want req=%0b x=%0d y=%0d",
                     req4, x4, y4, req8, x8, y8, exp_req, mh, mv);
        end
        e = '{de: 1'b0, hs: 1'b1, vs: 1'b1, fr: 1'b0, c4: 12'h0, c8: 24'h0};
        if (r && mrun) begin
            fs     = (mh == 0) && (mv == 0);
            effpat = fs ? pe : mpat;
            e.de   = exp_req;
            e.hs   = !(mh >= 10 && mh <= 12);
            e.vs   = !(mv == 5 || mv == 6);
            e.fr   = fs;
            if (exp_req) begin
                if (effpat) begin
                    e.c4 = bars4[mh];
                    e.c8 = bars8[mh];
                end else if (use_tbl) begin
                    e.c4 = t4;
                    e.c8 = t8;
                end else begin
                    e.c4 = xp4(px);
                    e.c8 = xp8(px);
                end
            end
            if (fs) mpat = pe;
            if (mh == 15) begin
                mh = 0;
                if (mv == 7) begin
                    mv = 0;
                    mframe++;
                end else begin
                    mv++;
                end
            end else begin
                mh++;
            end
        end else if (r) begin
            mrun = 1'b1;
        end else begin
            mrun = 1'b0;
            mh   = 0;
            mv   = 0;
            mpat = 1'b0;
        end
        sb_q.push_back(e);
        mon_en = 1'b1;
    endtask

    // Monitor: pop one expectation per rising edge and compare both instances.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: output cycle with no queued expectation");
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if ({de4, hs4, vs4, fr4, r4, g4, b4} !== {e.de, e.hs, e.vs, e.fr, e.c4}) begin
                        errors++;
                        $display("FAIL out4: got de=%0b hs=%0b vs=%0b fr=%0b rgb=%h%h%h want de=%0b hs=%0b vs=%0b fr=%0b rgb=%h",
                                 de4, hs4, vs4, fr4, r4, g4, b4, e.de, e.hs, e.vs, e.fr, e.c4);
                    end
                    checks++;
                    if ({de8, hs8, vs8, fr8, r8, g8, b8} !== {e.de, e.hs, e.vs, e.fr, e.c8}) begin
                        errors++;
                        $display("FAIL out8: got de=%0b hs=%0b vs=%0b fr=%0b rgb=%h%h%h want de=%0b hs=%0b vs=%0b fr=%0b rgb=%h",
                                 de8, hs8, vs8, fr8, r8, g8, b8, e.de, e.hs, e.vs, e.fr, e.c8);
                    end
                end
            end
        end
    end

    // Default-parameter instance: HSYNC period 800 and low width 96.
    initial begin
        int  last_fall = -1;
        int  falls = 0;
        int  rises = 0;
        bit  prev_hs = 1'b1;
        @(posedge rst_def_n);
        for (int cyc = 0; cyc < 2600; cyc++) begin
            @(negedge clk);
            if (prev_hs && !hsd) begin
                if (last_fall >= 0) begin
                    checks++;
                    if (cyc - last_fall != 800) begin
                        errors++;
                        $display("FAIL def_hperiod: got %0d cycles want 800", cyc - last_fall);
                    end
                end
                last_fall = cyc;
                falls++;
            end else if (!prev_hs && hsd && last_fall >= 0) begin
                rises++;
                checks++;
                if (cyc - last_fall != 96) begin
                    errors++;
                    $display("FAIL def_hswidth: got %0d cycles want 96", cyc - last_fall);
                end
            end
            prev_hs = hsd;
        end
        checks++;
        if (falls < 3 || rises < 3) begin
            errors++;
            $display("FAIL def_timeout: got %0d falls %0d rises want at least 3 each", falls, rises);
        end
        def_done = 1'b1;
    end

    // Main stimulus sequence.
    initial begin
        bit          r, pe, use_tbl;
        int          idx;
        logic [7:0]  px;
        logic [11:0] t4;
        logic [23:0] t8;
        rst_n     = 1'b0;
        rst_def_n = 1'b0;
        pat_en    = 1'b0;
        rgb       = 8'h00;
        repeat (2) @(posedge clk);
        for (int n = 0; n < 720; n++) begin
            @(negedge clk);
            if (n == 0) rst_def_n = 1'b1;
            r = 1'b1;
            if (n < 2) begin
                r = 1'b0;
            end else if (!pulse_done && mrun && mframe == 3 && mv == 2 && mh == 5) begin
                r = 1'b0;
                pulse_done = 1'b1;
            end
            pe = !pulse_done && (mframe > 1 || (mframe == 1 && mv >= 2));
            use_tbl = 1'b0;
            t4 = 12'h0;
            t8 = 24'h0;
            if (mframe == 1 && !pulse_done) begin
                idx     = mh % 3;
                px      = tbl_rgb[idx];
                t4      = tbl4[idx];
                t8      = tbl8[idx];
                use_tbl = 1'b1;
            end else begin
                px = {3'(mh), 3'(mv), 2'b00};
            end
            drive(r, pe, px, use_tbl, t4, t8);
        end
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        wait (def_done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_param_controller.md
# vga_param_controller

Parametrised VGA timing and pixel-output controller, the successor to the fixed 640x480 controller. It generates horizontal and vertical timing from parameters and issues a pixel request (coordinates) one cycle ahead of the colour output. It then expands an RGB332 input byte to a configurable per-channel output depth, and can substitute an internal colour-bar test pattern. It sits between the pixel source (frame buffer / game renderer) and the DAC pins.

## Interface
- H_ACTIVE, 640, visible pixels per line (multiple of 8)
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10; V_SYNC, 2; V_BP, 33, vertical porch/sync in lines
- HS_POL, 0, HSYNC asserted level (0 = active-low)
- VS_POL, 0, VSYNC asserted level
- OUT_BITS, 4, bits per output colour channel (2..8)
- CW, 10, width of the coordinate and counter fields (must hold H/V totals minus 1)

Ports:
- i_CLK  in  1  pixel clock
- i_RESET  in  1  synchronous, active-low reset
- i_RGB  in  8  pixel for the requested coordinate, RGB332 format {R[2:0],G[2:0],B[1:0]}
- i_PATTERN_EN  in  1  1 = internal colour bars, 0 = i_RGB
- o_REQ  out  1  the current (o_X,o_Y) is visible and i_RGB must carry it this cycle
- o_X  out  CW  requested column
- o_Y  out  CW  requested line
- o_HSYNC  out  1  horizontal sync
- o_VSYNC  out  1  vertical sync
- o_DE  out  1  colour outputs carry a visible pixel
- o_FRAME  out  1  one-cycle pulse, first pixel (0,0) of a frame on outputs
- o_RED / o_GREEN / o_BLUE  out  OUT_BITS each  colour outputs

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps and counts 0..V_TOTAL-1, wrapping to 0.
- o_X = h_cnt and o_Y = v_cnt, driven directly from the counter registers.
- o_REQ = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Horizontal sync region: H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. Vertical sync region uses v_cnt analogously and holds for whole lines.
- Output stage registers colour, DE, HSYNC, VSYNC and FRAME together, all one cycle behind the counters.
- Colour selection:
  - o_DE=0: all channels 0.
  - Input mode: each RGB332 field is expanded to OUT_BITS by MSB-first bit replication. At OUT_BITS=4: R=3'b101 gives 4'b1011; B=2'b10 gives 4'b1010.
  - Pattern mode: 8 equal vertical bars of width H_ACTIVE/8, tracked by a bar counter that resets at h_cnt=0. Bar order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or all-zeros.
- i_PATTERN_EN is sampled only when h_cnt=0 and v_cnt=0, so a mode change takes effect on a frame boundary and never tears mid-frame.
- o_FRAME is high in the output cycle that presents pixel (0,0).

## Timing
- Pixel latency is 1 cycle: i_RGB is sampled on the rising edge that ends an o_REQ=1 cycle. The matching colour, o_DE=1, HSYNC and VSYNC appear after that edge.
- i_RGB is don't-care when o_REQ=0, and is ignored in pattern mode.
- Reset (i_RESET=0 at an edge) forces the following state; mid-frame reset aborts the frame immediately:
  - h_cnt=v_cnt=0 and o_REQ=0.
  - o_HSYNC=~HS_POL and o_VSYNC=~VS_POL.
  - o_DE=0, o_FRAME=0, all colours 0.
  - Latched pattern mode = 0.
- First cycle after reset release: o_REQ=1 with (0,0). The next cycle: o_FRAME=1, o_DE=1.
- Wrap: at h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, both counters go to 0 on the same edge. There is no skipped or duplicated line.
- A frame is exactly H_TOTAL*V_TOTAL cycles. Default: 800*525 = 420000.

## Test plan
Small timing unless stated: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=16); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8).
- Reset release, then count cycles:
  - o_REQ high for cycles 0-7 of each line and low for 8-15.
  - o_HSYNC low exactly in output cycles 11-13 of each line.
  - o_VSYNC low for lines 5-6 (32 cycles).
  - o_FRAME pulses every 128 cycles.
- Drive i_RGB = o_X[2:0]<<5 | o_Y[2:0]<<2 (RGB332), OUT_BITS=4:
  - Every o_DE=1 cycle shows o_RED = replicate(previous cycle's X).
  - o_BLUE = 0.
  - o_DE=0 cycles show zeros.
- i_RGB=8'hFF then 8'h00 in input mode, at OUT_BITS=4 and at OUT_BITS=8:
  - 8'hFF gives F/F/F at 4 bits and FF/FF/FF at 8 bits.
  - 8'h00 gives all zeros.
- Raise i_PATTERN_EN mid-frame:
  - The current frame still follows i_RGB.
  - The next frame shows bars of width 1 at pixels 0..7: white, yellow, cyan, green, magenta, red, blue, black.
- Assert i_RESET=0 for 1 cycle at line 2, pixel 5:
  - All outputs take their reset values the next cycle.
  - The timing restarts at (0,0) with o_FRAME one cycle after release.
- Default parameters: measure 420000 cycles between o_FRAME pulses and 800 cycles between HSYNC falling edges.
